ifm_row_loader: RTL and testbench

- Services single-row IFM load requests from the CNN controller (o_ifm_buf_req_load / o_ifm_buf_req_row → this block; o_req_done → controller q_ifm_buf_done).
- Fetches one tiled row, q_width*q_channel words, from external memory through a burst read port.
- Writes the row into a circular multi-row IFM line buffer. Slot = row mod 2^W_SLOT.

---
 rtl/ifm_row_loader.sv | 127 ++++++++++++
 tb/tb_ifm_row_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifm_row_loader.sv
// Single-row IFM loader: fetches q_width*q_channel words of one row through a
// burst read port and writes them, in beat order, into a circular line buffer slot.
module ifm_row_loader #(
    parameter int W_SIZE     = 10,
    parameter int W_CHANNEL  = 10,
    parameter int W_DATA     = 32,
    parameter int W_ADDR     = 32,
    parameter int W_SLOT     = 2,
    parameter int W_BUF_WORD = 12,
    parameter int W_LEN      = 9,
    parameter int MAX_BURST  = 256
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         q_req_load,
    input  logic [W_SIZE-1:0]            q_req_row,
    input  logic [W_SIZE-1:0]            q_width,
    input  logic [W_CHANNEL-1:0]         q_channel,
    input  logic [W_ADDR-1:0]            q_base_addr,
    output logic                         o_req_done,
    output logic                         o_busy,
    output logic                         o_req_drop,
    output logic                         o_rd_req_valid,
    input  logic                         i_rd_req_ready,
    output logic [W_ADDR-1:0]            o_rd_addr,
    output logic [W_LEN-1:0]             o_rd_len,
    input  logic                         i_rd_data_valid,
    input  logic [W_DATA-1:0]            i_rd_data,
    output logic                         o_buf_we,
    output logic [W_SLOT+W_BUF_WORD-1:0] o_buf_addr,
    output logic [W_DATA-1:0]            o_buf_wdata
);
    localparam int BPW   = W_DATA / 8;
    localparam int W_CNT = W_BUF_WORD + 1;

    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_REQ, ST_RECV, ST_DONE} state_t;

    state_t                         r_state, w_next;
    logic [W_SIZE-1:0]              r_row;
    logic [W_SLOT-1:0]              r_slot;
    logic [W_CNT-1:0]               r_row_words, r_words_issued, w_remaining, w_row_words;
    logic [W_BUF_WORD-1:0]          r_words_recv;
    logic [W_ADDR-1:0]              r_row_base, w_row_off, w_burst_addr;
    logic [W_LEN-1:0]               r_burst_len, r_beat_cnt, w_len;
    logic                           w_accept, w_beat, w_last_beat;
    logic                           r_we, r_drop;
    logic [W_SLOT+W_BUF_WORD-1:0]   r_buf_addr;
    logic [W_DATA-1:0]              r_wdata;

    // Product taken at the truncated width directly; equals the low bits of the full product.
    assign w_row_words  = W_CNT'(W_CNT'(q_width) * W_CNT'(q_channel));
    assign w_row_off    = W_ADDR'(r_row) * W_ADDR'(r_row_words) * W_ADDR'(BPW);
    assign w_remaining  = r_row_words - r_words_issued;
    assign w_len        = (w_remaining >= W_CNT'(MAX_BURST)) ? W_LEN'(MAX_BURST) : W_LEN'(w_remaining);
    assign w_burst_addr = r_row_base + W_ADDR'(r_words_issued) * W_ADDR'(BPW);

    assign w_accept    = (r_state == ST_REQ) && i_rd_req_ready;
    assign w_beat      = (r_state == ST_RECV) && i_rd_data_valid;
    assign w_last_beat = w_beat && (r_beat_cnt == r_burst_len - W_LEN'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (q_req_load) w_next = ST_SETUP;
            ST_SETUP: w_next = (r_row_words == '0) ? ST_DONE : ST_REQ;
            ST_REQ:   if (w_accept) w_next = ST_RECV;
            ST_RECV:  if (w_last_beat) w_next = (r_words_issued < r_row_words) ? ST_REQ : ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_row          <= '0;
            r_slot         <= '0;
            r_row_words    <= '0;
            r_row_base     <= '0;
            r_words_issued <= '0;
            r_words_recv   <= '0;
            r_burst_len    <= '0;
            r_beat_cnt     <= '0;
            r_we           <= 1'b0;
            r_drop         <= 1'b0;
            r_buf_addr     <= '0;
            r_wdata        <= '0;
        end else begin
            r_we   <= w_beat;
            r_drop <= q_req_load && (r_state != ST_IDLE);
            if (r_state == ST_IDLE && q_req_load) begin
                r_row          <= q_req_row;
                r_slot         <= q_req_row[W_SLOT-1:0];
                r_row_words    <= w_row_words;
                r_words_issued <= '0;
                r_words_recv   <= '0;
            end
            if (r_state == ST_SETUP) r_row_base <= q_base_addr + w_row_off;
            if (w_accept) begin
                r_words_issued <= r_words_issued + W_CNT'(w_len);
                r_burst_len    <= w_len;
                r_beat_cnt     <= '0;
            end
            if (w_beat) begin
                r_buf_addr   <= {r_slot, r_words_recv};
                r_wdata      <= i_rd_data;
                r_words_recv <= r_words_recv + W_BUF_WORD'(1);
                r_beat_cnt   <= r_beat_cnt + W_LEN'(1);
            end
        end
    end

    assign o_busy         = (r_state != ST_IDLE);
    assign o_req_done     = (r_state == ST_DONE);
    assign o_req_drop     = r_drop;
    assign o_rd_req_valid = (r_state == ST_REQ);
    assign o_rd_addr      = o_rd_req_valid ? w_burst_addr : '0;
    assign o_rd_len       = o_rd_req_valid ? w_len : '0;
    assign o_buf_we       = r_we;
    assign o_buf_addr     = r_buf_addr;
    assign o_buf_wdata    = r_wdata;

endmodule

// File: tb/tb_ifm_row_loader.sv
// Scoreboard bench for ifm_row_loader: expected bursts and buffer writes are queued
// at request time; a memory responder and a write monitor pop and compare.
module tb_ifm_row_loader;
    typedef struct {logic [13:0] a; logic [31:0] d; bit lst;} wr_t;
    typedef struct {logic [31:0] a; logic [8:0] l;} bu_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        q_req_load;
    logic [9:0]  q_req_row, q_width;
    logic [9:0]  q_channel;
    logic [31:0] q_base_addr;
    logic        o_req_done, o_busy, o_req_drop, o_rd_req_valid;
    logic        rd_ready, rd_valid, stray_valid;
    logic [31:0] o_rd_addr, rd_data, o_buf_wdata;
    logic [8:0]  o_rd_len;
    logic        o_buf_we;
    logic [13:0] o_buf_addr;

    wr_t wq[$];
    bu_t bq[$];
    int  n_chk = 0, n_fail = 0;
    int  done_cnt = 0, drop_cnt = 0, wr_cnt = 0;
    int  rdy_delay = 0;
    bit  gap = 1'b0;

    always #5 clk = ~clk;

    ifm_row_loader #(
        .W_SIZE(10), .W_CHANNEL(10), .W_DATA(32), .W_ADDR(32),
        .W_SLOT(2), .W_BUF_WORD(12), .W_LEN(9), .MAX_BURST(256)
    ) dut (
        .clk(clk), .rstn(rstn),
        .q_req_load(q_req_load), .q_req_row(q_req_row), .q_width(q_width),
        .q_channel(q_channel), .q_base_addr(q_base_addr),
        .o_req_done(o_req_done), .o_busy(o_busy), .o_req_drop(o_req_drop),
        .o_rd_req_valid(o_rd_req_valid), .i_rd_req_ready(rd_ready),
        .o_rd_addr(o_rd_addr), .o_rd_len(o_rd_len),
        .i_rd_data_valid(rd_valid | stray_valid), .i_rd_data(rd_data),
        .o_buf_we(o_buf_we), .o_buf_addr(o_buf_addr), .o_buf_wdata(o_buf_wdata)
    );

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_we"}, o_buf_we, 0);
        chk({tag, "_rdv"}, o_rd_req_valid, 0);
        chk({tag, "_done"}, o_req_done, 0);
        chk({tag, "_drop"}, o_req_drop, 0);
        chk({tag, "_outs"}, {o_rd_addr, o_rd_len, o_buf_addr}, 0);
        chk({tag, "_wdata"}, o_buf_wdata, 0);
    endtask

    // Write monitor: every buffer write must match the head of the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (o_req_done) done_cnt++;
        if (o_req_drop) drop_cnt++;
        if (o_buf_we) begin
            wr_cnt++;
            if (wq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected none", o_buf_addr, o_buf_wdata);
            end else begin
                e = wq.pop_front();
                chk("wr_addr", o_buf_addr, e.a);
                chk("wr_data", o_buf_wdata, e.d);
                chk("done_with_last_write", o_req_done, e.lst);
            end
        end
    end

    // Memory responder: memory word at byte address A holds ~A.
    initial begin
        logic [31:0] cur_a;
        logic [8:0]  cur_l;
        bu_t         b;
        rd_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
        forever begin
            @(posedge clk); #1;
            if (o_rd_req_valid) begin
                for (int d = 0; d < rdy_delay; d++) begin @(posedge clk); #1; end
                rd_ready = 1'b1;
                cur_a = o_rd_addr;
                cur_l = o_rd_len;
                if (bq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_burst: got addr %0h len %0d, expected none", cur_a, cur_l);
                end else begin
                    b = bq.pop_front();
                    chk("burst_addr", cur_a, b.a);
                    chk("burst_len", cur_l, b.l);
                end
                @(posedge clk); #1;
                rd_ready = 1'b0;
                for (int k = 0; k < int'(cur_l); k++) begin
                    rd_valid = 1'b1;
                    rd_data  = ~(cur_a + 32'(4 * k));
                    @(posedge clk); #1;
                    if (gap && (k % 5 == 2)) begin rd_valid = 1'b0; @(posedge clk); #1; end
                end
                rd_valid = 1'b0;
            end
        end
    end

    task automatic push_row(input logic [9:0] row, input logic [31:0] exp_base, input int words, input int n_wr);
        int rem, off, l;
        for (int k = 0; k < n_wr; k++)
            wq.push_back('{a: {row[1:0], 12'(k)}, d: ~(exp_base + 32'(4 * k)), lst: (k == words - 1)});
        rem = words; off = 0;
        while (rem > 0) begin
            l = (rem > 256) ? 256 : rem;
            bq.push_back('{a: exp_base + 32'(4 * off), l: 9'(l)});
            off += l; rem -= l;
        end
    endtask

    task automatic do_load(input logic [9:0] row, input logic [9:0] w, input logic [9:0] c,
                           input logic [31:0] base, input logic [31:0] exp_base,
                           input int words, input bit ovl);
        int lat, d0, budget;
        q_width = w; q_channel = c; q_base_addr = base;
        push_row(row, exp_base, words, words);
        d0 = done_cnt;
        @(posedge clk); #1;
        q_req_load = 1'b1; q_req_row = row;
        @(posedge clk); #1;
        q_req_load = 1'b0;
        lat = 1;
        while (!o_rd_req_valid && !o_req_done && lat < 10) begin @(posedge clk); #1; lat++; end
        if (words == 0) begin
            chk("zero_done_latency", lat, 2);
            chk("zero_no_request", o_rd_req_valid, 0);
        end else begin
            chk("req_latency", lat, 2);
        end
        if (ovl) begin
            repeat (3) begin @(posedge clk); #1; end
            q_req_load = 1'b1; q_req_row = row + 10'd1;
            @(posedge clk); #1;
            q_req_load = 1'b0;
            chk("drop_pulse", o_req_drop, 1);
            @(posedge clk); #1;
            chk("drop_one_cycle", o_req_drop, 0);
        end
        budget = 0;
        while (!o_req_done && budget < 3000) begin @(posedge clk); #1; budget++; end
        chk("done_seen", o_req_done, 1);
        chk("busy_in_done", o_busy, 1);
        @(posedge clk); #1;
        chk("busy_after_done", o_busy, 0);
        chk("done_one_cycle", o_req_done, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("single_done", done_cnt - d0, 1);
        chk("writes_drained", wq.size(), 0);
        chk("bursts_drained", bq.size(), 0);
    endtask

    initial begin
        int w0, d0, budget;
        rstn = 1'b0; q_req_load = 1'b0; q_req_row = '0;
        q_width = '0; q_channel = '0; q_base_addr = '0; stray_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Basic load: 16 words, one burst at 0x1000 + 3*16*4.
        do_load(10'd3, 10'd8, 10'd2, 32'h1000, 32'h10C0, 16, 1'b0);

        // Multi-burst: 500 words at 0x2000 + 1*500*4 = 0x27D0, slow ready, gappy beats.
        rdy_delay = 3; gap = 1'b1;
        do_load(10'd1, 10'd100, 10'd5, 32'h2000, 32'h27D0, 500, 1'b0);
        rdy_delay = 0; gap = 1'b0;

        // Slot wrap: rows 0..5, 4 words each, base 0.
        for (int r = 0; r < 6; r++)
            do_load(10'(r), 10'd4, 10'd1, 32'h0, 32'(16 * r), 4, 1'b0);

        // Overlapping request is dropped.
        do_load(10'd2, 10'd8, 10'd2, 32'h1000, 32'h1080, 16, 1'b1);
        chk("drop_count", drop_cnt, 1);

        // Zero-size row.
        do_load(10'd7, 10'd8, 10'd0, 32'h1000, 32'h1000, 0, 1'b0);

        // Stray read beats while idle must not write.
        w0 = wr_cnt;
        @(posedge clk); #1;
        stray_valid = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        stray_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("stray_no_write", wr_cnt - w0, 0);

        // Reset after 7 of 16 beats: no further writes, no done.
        w0 = wr_cnt; d0 = done_cnt;
        q_width = 10'd8; q_channel = 10'd2; q_base_addr = 32'h1000;
        push_row(10'd3, 32'h10C0, 16, 7);
        @(posedge clk); #1;
        q_req_load = 1'b1; q_req_row = 10'd3;
        @(posedge clk); #1;
        q_req_load = 1'b0;
        budget = 0;
        while (wr_cnt < w0 + 7 && budget < 200) begin @(negedge clk); #1; budget++; end
        chk("pre_reset_writes", wr_cnt - w0, 7);
        rstn = 1'b0;
        #1;
        check_zero("async_reset");
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("reset_no_more_writes", wr_cnt - w0, 7);
        chk("reset_no_done", done_cnt - d0, 0);
        chk("reset_wq_empty", wq.size(), 0);

        // A fresh request after reset completes normally.
        do_load(10'd3, 10'd8, 10'd2, 32'h1000, 32'h10C0, 16, 1'b0);
        chk("final_drop_count", drop_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time exceeded, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end
endmodule
